prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer-side counterpart of the instruction fetch path. It accepts a framed program stream over a valid/ready byte interface and writes it into the instruction RAM that the control unit reads.
- Holds the CPU in reset while loading. Releases it only after the checksum verifies.
- Sits between an external host link and the instruction memory write port, alongside the top-level core.

Parameters:
- INST_WIDTH, 8, instruction word width; also the stream word width.
- ADDR_WIDTH, 5, instruction memory address width; capacity 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 255, idle-cycle limit; used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, RUN or ERROR.
- in_data  input  INST_WIDTH  stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a word this cycle.
- mem_we  output  1  instruction RAM write enable.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  INST_WIDTH  write data.
- cpu_rst  output  1  reset to the core (control_unit/data_path); active-high.
- busy  output  1  load in progress.
- done  output  1  program loaded and verified; core running.
- err  output  1  load failed.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0. State=IDLE, count=0, csum=0.
- Transfer: a word moves only in a cycle where in_valid & in_ready are both 1. in_ready depends only on state, never on in_valid.
- States:
  - IDLE: on start -> LEN; clear csum, addr and err.
  - LEN: the accepted word is the length L.
    - L > 2^ADDR_WIDTH -> ERROR.
    - L == 0 -> CSUM.
    - Otherwise -> DATA with remaining=L.
  - DATA: each accepted word is written to address addr; csum ^= word; addr++; remaining--. After the L-th word -> CSUM.
  - CSUM: the accepted word is compared to csum.
    - Equal -> RUN.
    - Otherwise -> ERROR.
  - RUN: done=1, cpu_rst=0. start -> LEN (cpu_rst reasserts the next cycle).
  - ERROR: err=1, cpu_rst=1. start -> LEN.
- Outputs by state:
  - in_ready=1 only in LEN, DATA and CSUM.
  - busy=1 in LEN, DATA and CSUM.
  - cpu_rst=0 only in RUN.
- Write latency: mem_we, mem_addr and mem_wdata are registered. mem_we pulses the cycle after each DATA acceptance, with the address and data of that word. No write occurs for the length or checksum words.
- Back-to-back: one word per cycle sustained. mem_we may stay high across consecutive cycles.
- Wrap: with L == 2^ADDR_WIDTH, the final write is to the top address. addr wraps to 0 internally but is not used again.
- Write draining: the RUN transition occurs no earlier than the cycle after the last mem_we. cpu_rst never deasserts while a write is pending.
- start while busy is ignored.
- start in the same cycle as a transfer in IDLE: start takes effect; no word is consumed.
- Reset mid-load: asynchronous return to the reset values. Partially written memory contents are undefined. The core stays in reset.
- Checksum is the XOR over data words only; the length word is excluded.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in LEN, DATA and CSUM. It clears on every transfer.
  - When it reaches TIMEOUT_CYCLES with no transfer -> ERROR (err=1).
  - The counter clears on state entry.
- Undefined: no counter logic. The loader waits indefinitely for in_valid.

Test Plan:
- start; stream L=3, A1, 07, 3C, csum=A1^07^3C=9A -> writes (0,A1),(1,07),(2,3C), each one cycle after acceptance; RUN; done=1; cpu_rst=0.
- Same frame with csum=9B -> three writes occur, then ERROR; err=1; cpu_rst stays 1; a new start re-enters LEN with err cleared.
- L=33 (ADDR_WIDTH=5) -> ERROR immediately; no mem_we; L=0 followed by csum 00 -> RUN with no writes.
- L=32, words 00..1F with continuous in_valid -> 32 consecutive mem_we cycles at addresses 0..31; csum 00 -> RUN.
- Assert rst during DATA after 2 of 5 words -> all outputs at reset values asynchronously; start then a full valid frame -> RUN.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=10: stall in_valid for 10 cycles in DATA -> ERROR; a stall of 9 cycles then resume -> completes to RUN.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: loads a length/data/checksum byte frame into instruction RAM and holds the core in reset until it verifies.
// Latency: RAM write registered one cycle after each data-word acceptance; RUN entered the cycle after the checksum word.
// Backpressure: in_ready is a pure function of state; LOADER_TIMEOUT_EN adds an idle-cycle abort to ERROR.
module prog_loader #(
   parameter int INST_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [INST_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [INST_WIDTH-1:0] mem_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int RW    = ADDR_WIDTH + 1;
   localparam int LW    = (INST_WIDTH > RW) ? INST_WIDTH : RW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RW-1:0]         remaining_q, remaining_d;
   logic [INST_WIDTH-1:0] csum_q, csum_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [INST_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic                  xfer;
   logic                  timeout_hit;
   logic [LW-1:0]         len_ext;

   assign xfer    = in_valid & in_ready;
   assign len_ext = LW'(in_data);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a transfer always wins over a timeout in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            if (start) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (xfer) begin
               if (len_ext > LW'(DEPTH)) begin
                  state_d = S_ERROR;
               end else if (len_ext == '0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end else if (timeout_hit) begin
               state_d = S_ERROR;
            end
         end
         S_DATA: begin
            if (xfer) begin
               if (remaining_q == RW'(1)) begin
                  state_d = S_CSUM;
               end
            end else if (timeout_hit) begin
               state_d = S_ERROR;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? S_RUN : S_ERROR;
            end else if (timeout_hit) begin
               state_d = S_ERROR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      cpu_rst  = 1'b1;
      case (state_q)
         S_LEN, S_DATA, S_CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_RUN: begin
            done    = 1'b1;
            cpu_rst = 1'b0;
         end
         S_ERROR: begin
            err = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: running checksum, write pointer and the registered RAM write port
   always_comb begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            if (start) begin
               addr_d      = '0;
               remaining_d = '0;
               csum_d      = '0;
            end
         end
         S_LEN: begin
            if (xfer && (len_ext <= LW'(DEPTH))) begin
               remaining_d = RW'(in_data);
            end
         end
         S_DATA: begin
            if (xfer) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = in_data;
               csum_d      = csum_q ^ in_data;
               addr_d      = addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - RW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         remaining_q <= '0;
         csum_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   // Every state change out of LEN/DATA/CSUM rides on a transfer, so clearing on
   // transfer or outside the busy states also clears the count on state entry.
   always_comb begin
      idle_cnt_d = '0;
      if (busy && !xfer) begin
         idle_cnt_d = idle_cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign timeout_hit = busy && !xfer && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
`endif

endmodule
